// File: rtl/bps_gen_multi_if.sv
// Control and strobe bundle between the UART shifters and the baud-tick generator.
// The generator is the slave; whoever selects rates and re-aligns RX timing is the master.
interface bps_gen_multi_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       baud_sel;
    logic [CNT_W-1:0] div_custom;
    logic             tx_clr;
    logic             rx_en;
    logic             rx_start;
    logic             tx_tick;
    logic             rx_mid_tick;
    logic             rx_os_tick;
    logic [CNT_W-1:0] bps_num;

    modport master (
        output baud_sel, div_custom, tx_clr, rx_en, rx_start,
        input  tx_tick, rx_mid_tick, rx_os_tick, bps_num
    );

    modport slave (
        input  baud_sel, div_custom, tx_clr, rx_en, rx_start,
        output tx_tick, rx_mid_tick, rx_os_tick, bps_num
    );
endinterface

// File: rtl/bps_gen_multi.sv
// Baud-tick generator: TX bit strobe plus RX mid-bit and oversample strobes from one clock.
// The active divisor only changes on TX period boundaries so no strobe is ever shortened mid-bit.
module bps_gen_multi #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int CNT_W    = 16,
    parameter int OVS_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    bps_gen_multi_if.slave   bus
);
    localparam int DIV_9600   = (CLK_HZ + 9600 / 2) / 9600;
    localparam int DIV_19200  = (CLK_HZ + 19200 / 2) / 19200;
    localparam int DIV_38400  = (CLK_HZ + 38400 / 2) / 38400;
    localparam int DIV_57600  = (CLK_HZ + 57600 / 2) / 57600;
    localparam int DIV_115200 = (CLK_HZ + 115200 / 2) / 115200;
    localparam int DIV_230400 = (CLK_HZ + 230400 / 2) / 230400;
    localparam int DIV_460800 = (CLK_HZ + 460800 / 2) / 460800;
    localparam int DIV_921600 = (CLK_HZ + 921600 / 2) / 921600;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    // A divisor of 1 would make every cycle a wrap and break the half-bit math.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        if (v < CNT_TWO) begin
            clamp_div = CNT_TWO;
        end else begin
            clamp_div = v;
        end
    endfunction

    logic [CNT_W-1:0] sel_raw_s;
    logic [CNT_W-1:0] sel_div_s;
    logic [CNT_W-1:0] half_raw_s;
    logic [CNT_W-1:0] half_s;
    logic [CNT_W-1:0] os_raw_s;
    logic [CNT_W-1:0] os_div_s;
    logic [CNT_W-1:0] rx_target_s;

    logic [CNT_W-1:0] bps_num_q, bps_num_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             tx_tick_q, tx_tick_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
    logic             first_q, first_d;
    logic             rx_mid_tick_q, rx_mid_tick_d;
    logic             rx_os_tick_q, rx_os_tick_d;

    // Rate table lookup; unused codes fall back to 115200.
    always_comb begin
        sel_raw_s = CNT_W'(DIV_115200);
        case (bus.baud_sel)
            4'd0:    sel_raw_s = bus.div_custom;
            4'd1:    sel_raw_s = CNT_W'(DIV_9600);
            4'd2:    sel_raw_s = CNT_W'(DIV_19200);
            4'd3:    sel_raw_s = CNT_W'(DIV_38400);
            4'd4:    sel_raw_s = CNT_W'(DIV_57600);
            4'd5:    sel_raw_s = CNT_W'(DIV_115200);
            4'd6:    sel_raw_s = CNT_W'(DIV_230400);
            4'd7:    sel_raw_s = CNT_W'(DIV_460800);
            4'd8:    sel_raw_s = CNT_W'(DIV_921600);
            default: sel_raw_s = CNT_W'(DIV_115200);
        endcase
        sel_div_s = clamp_div(sel_raw_s);
    end

    // Half-bit and oversample periods derived from the active divisor, floored at one cycle.
    always_comb begin
        half_raw_s = bps_num_q >> 1;
        os_raw_s   = bps_num_q >> OVS_LOG2;
        if (half_raw_s == '0) begin
            half_s = CNT_ONE;
        end else begin
            half_s = half_raw_s;
        end
        if (os_raw_s == '0) begin
            os_div_s = CNT_ONE;
        end else begin
            os_div_s = os_raw_s;
        end
        if (first_q) begin
            rx_target_s = half_s;
        end else begin
            rx_target_s = bps_num_q;
        end
    end

    // TX bit timing; clear beats a coincident wrap. The >= compare lets a shrunk divisor wrap at once.
    always_comb begin
        bps_num_d = bps_num_q;
        tx_cnt_d  = tx_cnt_q + CNT_ONE;
        tx_tick_d = 1'b0;
        if (bus.tx_clr) begin
            bps_num_d = sel_div_s;
            tx_cnt_d  = CNT_ONE;
            tx_tick_d = 1'b0;
        end else if (tx_cnt_q >= bps_num_q) begin
            bps_num_d = sel_div_s;
            tx_cnt_d  = CNT_ONE;
            tx_tick_d = 1'b1;
        end else begin
            bps_num_d = bps_num_q;
            tx_cnt_d  = tx_cnt_q + CNT_ONE;
            tx_tick_d = 1'b0;
        end
    end

    // RX mid-bit and oversample timing; a start pulse (or disable) restarts both and suppresses ticks.
    always_comb begin
        rx_cnt_d      = rx_cnt_q + CNT_ONE;
        os_cnt_d      = os_cnt_q + CNT_ONE;
        first_d       = first_q;
        rx_mid_tick_d = 1'b0;
        rx_os_tick_d  = 1'b0;
        if (!bus.rx_en || bus.rx_start) begin
            rx_cnt_d      = CNT_ONE;
            os_cnt_d      = CNT_ONE;
            first_d       = 1'b1;
            rx_mid_tick_d = 1'b0;
            rx_os_tick_d  = 1'b0;
        end else begin
            if (rx_cnt_q >= rx_target_s) begin
                rx_cnt_d      = CNT_ONE;
                first_d       = 1'b0;
                rx_mid_tick_d = 1'b1;
            end else begin
                rx_cnt_d      = rx_cnt_q + CNT_ONE;
                first_d       = first_q;
                rx_mid_tick_d = 1'b0;
            end
            if (os_cnt_q >= os_div_s) begin
                os_cnt_d     = CNT_ONE;
                rx_os_tick_d = 1'b1;
            end else begin
                os_cnt_d     = os_cnt_q + CNT_ONE;
                rx_os_tick_d = 1'b0;
            end
        end
    end

    // State and output registers; reset loads the currently selected divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            bps_num_q     <= sel_div_s;
            tx_cnt_q      <= CNT_ONE;
            tx_tick_q     <= 1'b0;
            rx_cnt_q      <= CNT_ONE;
            os_cnt_q      <= CNT_ONE;
            first_q       <= 1'b1;
            rx_mid_tick_q <= 1'b0;
            rx_os_tick_q  <= 1'b0;
        end else begin
            bps_num_q     <= bps_num_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_tick_q     <= tx_tick_d;
            rx_cnt_q      <= rx_cnt_d;
            os_cnt_q      <= os_cnt_d;
            first_q       <= first_d;
            rx_mid_tick_q <= rx_mid_tick_d;
            rx_os_tick_q  <= rx_os_tick_d;
        end
    end

    assign bus.tx_tick     = tx_tick_q;
    assign bus.rx_mid_tick = rx_mid_tick_q;
    assign bus.rx_os_tick  = rx_os_tick_q;
    assign bus.bps_num     = bps_num_q;
endmodule

// File: tb/tb_bps_gen_multi.sv
// Bench for bps_gen_multi: divisor table vectors, directed timing sequences and a random
// run checked every cycle against an elapsed-time model of the tick rules.
module tb_bps_gen_multi;
    localparam int CW     = 16;
    localparam int CLK_HZ = 100_000_000;

    typedef struct {
        logic [3:0]    sel;
        logic [CW-1:0] cust;
        int            exp_bps;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bps_gen_multi_if #(.CNT_W(CW)) bus ();

    bps_gen_multi #(.CLK_HZ(CLK_HZ), .CNT_W(CW), .OVS_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rel   = 0;
    longint n = 0;
    int q_tx[$];
    int q_mid[$];
    int q_os[$];

    // Model state: times (edge index) of the last restart of each strobe and the active period.
    longint m_p, a_tx, a_rx, a_os;
    bit     m_first, m_valid = 1'b0;
    bit     e_tx, e_mid, e_os;

    function automatic longint ref_div(input logic [3:0] sel, input logic [CW-1:0] cust);
        longint rate;
        longint d;
        case (sel)
            4'd1: rate = 9600;
            4'd2: rate = 19200;
            4'd3: rate = 38400;
            4'd4: rate = 57600;
            4'd6: rate = 230400;
            4'd7: rate = 460800;
            4'd8: rate = 921600;
            default: rate = 115200;
        endcase
        if (sel == 4'd0) d = longint'(cust);
        else d = (CLK_HZ + rate / 2) / rate;
        d = d % 65536;
        if (d < 2) d = 2;
        return d;
    endfunction

    function automatic longint lmax1(input longint v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic model_step();
        longint sel_d, p_old, tgt;
        sel_d = ref_div(bus.baud_sel, bus.div_custom);
        p_old = m_p;
        if (rst) begin
            m_p = sel_d; a_tx = n; a_rx = n; a_os = n;
            m_first = 1'b1; e_tx = 1'b0; e_mid = 1'b0; e_os = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (bus.tx_clr) begin
                a_tx = n; m_p = sel_d; e_tx = 1'b0;
            end else if (n - a_tx >= p_old) begin
                a_tx = n; m_p = sel_d; e_tx = 1'b1;
            end else begin
                e_tx = 1'b0;
            end
            if (!bus.rx_en || bus.rx_start) begin
                a_rx = n; a_os = n; m_first = 1'b1; e_mid = 1'b0; e_os = 1'b0;
            end else begin
                tgt = m_first ? lmax1(p_old / 2) : p_old;
                if (n - a_rx >= tgt) begin
                    a_rx = n; m_first = 1'b0; e_mid = 1'b1;
                end else begin
                    e_mid = 1'b0;
                end
                if (n - a_os >= lmax1(p_old / 16)) begin
                    a_os = n; e_os = 1'b1;
                end else begin
                    e_os = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        n++;
        #1;
        if (m_valid) begin
            total++;
            if ({bus.tx_tick, bus.rx_mid_tick, bus.rx_os_tick} !== {e_tx, e_mid, e_os} ||
                bus.bps_num !== CW'(m_p)) begin
                bad++;
                if (bad <= 20)
                    $display("FAIL model edge %0d: got tx/mid/os=%b%b%b bps=%0d expected %b%b%b bps=%0d",
                             n - 1, bus.tx_tick, bus.rx_mid_tick, bus.rx_os_tick, bus.bps_num,
                             e_tx, e_mid, e_os, m_p);
            end
        end
        rel++;
        if (bus.tx_tick === 1'b1)     q_tx.push_back(rel);
        if (bus.rx_mid_tick === 1'b1) q_mid.push_back(rel);
        if (bus.rx_os_tick === 1'b1)  q_os.push_back(rel);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic clearq();
        q_tx.delete(); q_mid.delete(); q_os.delete();
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{4'd1,  16'd0,     10417};
        vecs[1]  = '{4'd2,  16'd0,     5208};
        vecs[2]  = '{4'd3,  16'd0,     2604};
        vecs[3]  = '{4'd4,  16'd0,     1736};
        vecs[4]  = '{4'd6,  16'd0,     434};
        vecs[5]  = '{4'd7,  16'd0,     217};
        vecs[6]  = '{4'd8,  16'd0,     109};
        vecs[7]  = '{4'd12, 16'd0,     868};
        vecs[8]  = '{4'd0,  16'd0,     2};
        vecs[9]  = '{4'd0,  16'd1,     2};
        vecs[10] = '{4'd0,  16'd40,    40};
        vecs[11] = '{4'd0,  16'd65535, 65535};

        bus.baud_sel = 4'd5; bus.div_custom = 16'd0; bus.tx_clr = 1'b0;
        bus.rx_en = 1'b0; bus.rx_start = 1'b0; rst = 1'b1;
        cyc(); cyc();
        chk("reset_tx_tick", bus.tx_tick, 0);
        chk("reset_mid", bus.rx_mid_tick, 0);
        chk("reset_os", bus.rx_os_tick, 0);
        chk("reset_bps", bus.bps_num, 868);
        rst = 1'b0;

        foreach (vecs[i]) begin
            bus.baud_sel = vecs[i].sel; bus.div_custom = vecs[i].cust; bus.tx_clr = 1'b1;
            cyc();
            bus.tx_clr = 1'b0;
            chk("table_bps", bus.bps_num, vecs[i].exp_bps);
        end

        // TX period at 115200 after clear
        bus.baud_sel = 4'd5; rst = 1'b1; cyc(); rst = 1'b0;
        rel = -1; bus.tx_clr = 1'b1; cyc(); bus.tx_clr = 1'b0; clearq();
        run(2700);
        chk("tx868_count", q_tx.size(), 3);
        chk("tx868_t0", qat(q_tx, 0), 868);
        chk("tx868_t1", qat(q_tx, 1), 1736);
        chk("tx868_t2", qat(q_tx, 2), 2604);

        // rate change mid-period applies from the next tick
        bus.baud_sel = 4'd8; clearq();
        run(1000);
        chk("switch_t0", qat(q_tx, 0), 3472);
        chk("switch_t1", qat(q_tx, 1), 3581);
        chk("switch_t2", qat(q_tx, 2), 3690);
        chk("switch_bps", bus.bps_num, 109);

        // custom divisor clamp and small oversample period
        bus.baud_sel = 4'd0; bus.div_custom = 16'd1;
        rel = -1; bus.tx_clr = 1'b1; cyc(); bus.tx_clr = 1'b0; clearq();
        run(10);
        chk("clamp_bps", bus.bps_num, 2);
        chk("clamp_count", q_tx.size(), 5);
        chk("clamp_last", qat(q_tx, 4), 10);
        bus.div_custom = 16'd40; bus.rx_en = 1'b1;
        rel = -1; bus.tx_clr = 1'b1; bus.rx_start = 1'b1; cyc();
        bus.tx_clr = 1'b0; bus.rx_start = 1'b0; clearq();
        run(20);
        chk("os40_count", q_os.size(), 10);
        chk("os40_first", qat(q_os, 0), 2);
        chk("os40_last", qat(q_os, 9), 20);
        chk("mid40_first", qat(q_mid, 0), 20);

        // RX at 9600
        bus.baud_sel = 4'd1; bus.tx_clr = 1'b1; cyc(); bus.tx_clr = 1'b0;
        rel = -1; bus.rx_start = 1'b1; cyc(); bus.rx_start = 1'b0; clearq();
        run(26100);
        chk("rx9600_count", q_mid.size(), 3);
        chk("rx9600_m0", qat(q_mid, 0), 5208);
        chk("rx9600_m1", qat(q_mid, 1), 15625);
        chk("rx9600_m2", qat(q_mid, 2), 26042);
        chk("os651_count", q_os.size(), 40);
        chk("os651_o0", qat(q_os, 0), 651);
        chk("os651_o1", qat(q_os, 1), 1302);

        // start re-issued mid-bit realigns timing
        rel = -1; bus.rx_start = 1'b1; cyc(); bus.rx_start = 1'b0;
        run(2999);
        bus.rx_start = 1'b1; cyc(); bus.rx_start = 1'b0; clearq();
        run(5300);
        chk("realign_count", q_mid.size(), 1);
        chk("realign_m0", qat(q_mid, 0), 8208);

        // start ignored while disabled
        bus.rx_en = 1'b0; clearq();
        for (int i = 0; i < 2000; i++) begin
            bus.rx_start = (i % 100 == 0);
            cyc();
        end
        bus.rx_start = 1'b0;
        chk("rxoff_mid", q_mid.size(), 0);
        chk("rxoff_os", q_os.size(), 0);
        bus.rx_en = 1'b1;

        // clear on the wrap cycle, then reset mid-period
        bus.baud_sel = 4'd5;
        rel = -1; bus.tx_clr = 1'b1; cyc(); bus.tx_clr = 1'b0;
        run(867);
        bus.tx_clr = 1'b1; cyc(); bus.tx_clr = 1'b0;
        chk("clr_wrap_tick", bus.tx_tick, 0);
        clearq();
        run(900);
        chk("clr_wrap_next", qat(q_tx, 0), 1736);
        run(231);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_mid_tx", bus.tx_tick, 0);
        chk("rst_mid_rx", bus.rx_mid_tick, 0);
        chk("rst_mid_os", bus.rx_os_tick, 0);
        chk("rst_mid_bps", bus.bps_num, 868);
        clearq();
        run(900);
        chk("rst_next", qat(q_tx, 0), 2868);

        // random stimulus against the model
        bus.baud_sel = 4'd0; bus.div_custom = 16'd37; bus.rx_en = 1'b1;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin bus.baud_sel = 4'd0; bus.div_custom = CW'($urandom_range(0, 80)); end
                    1: bus.baud_sel = 4'd8;
                    2: bus.baud_sel = 4'd7;
                    default: bus.baud_sel = 4'($urandom_range(9, 15));
                endcase
            end
            bus.tx_clr   = ($urandom_range(0, 149) == 0);
            bus.rx_start = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 499) == 0) bus.rx_en = ~bus.rx_en;
            rst = ($urandom_range(0, 1999) == 0);
            cyc();
        end
        rst = 1'b0; bus.tx_clr = 1'b0; bus.rx_start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bps_gen_multi.md
# bps_gen_multi

Parametrised baud-tick generator for the RS485 UART path. It generates an independent TX bit tick and RX timing strobes from one system clock. RX timing consists of a mid-bit sample strobe, re-aligned on every start-bit detection, and an oversampling strobe. The baud rate is selected at runtime from a table computed from `CLK_HZ`, or from a custom divisor. Divisor changes take effect only on period boundaries, so ticks never glitch. The block feeds the TX shifter (`tx_tick`) and the RX deserialiser (`rx_mid_tick`, `rx_os_tick`).

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz; used for divisor table constants.
- `CNT_W`, 16, width of divisor and counters.
- `OVS_LOG2`, 4, log2 of RX oversampling factor (16x).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `baud_sel`  in  4  rate select: 0 custom, 1 9600, 2 19200, 3 38400, 4 57600, 5 115200, 6 230400, 7 460800, 8 921600, 9–15 → 115200.
- `div_custom`  in  CNT_W  divisor used when `baud_sel`=0.
- `tx_clr`  in  1  restart TX bit timing.
- `rx_en`  in  1  enable RX timing; low holds RX counters idle.
- `rx_start`  in  1  one-cycle pulse at detected start-bit edge; re-aligns RX timing.
- `tx_tick`  out  1  one-cycle TX bit strobe, period `bps_num` cycles.
- `rx_mid_tick`  out  1  one-cycle RX mid-bit sample strobe.
- `rx_os_tick`  out  1  one-cycle RX oversample strobe.
- `bps_num`  out  CNT_W  active divisor (clock cycles per bit).

## Operation
- Table divisor for rate B = (CLK_HZ + B/2)/B, computed as localparams. At 100 MHz: 10417, 5208, 2604, 1736, 868, 434, 217, 109.
- Custom divisor below 2 is clamped to 2. Divisors are truncated to CNT_W bits.
- `bps_num` loads the selected divisor on `rst`, on `tx_clr`, and on the cycle `tx_tick` is generated. It holds at all other times.
- TX counter `tx_cnt`:
  - Set to 1 on `rst` or `tx_clr`.
  - When `tx_cnt`==`bps_num`: set to 1 and register `tx_tick`=1.
  - Otherwise: increment and `tx_tick`=0.
- Derived RX values:
  - `half` = max(`bps_num`>>1, 1).
  - `os_div` = max(`bps_num`>>OVS_LOG2, 1).
- RX with `rx_en`=0: `rx_cnt` and `os_cnt` held at 1, `first`=1, both RX ticks 0. `rx_start` is ignored.
- `rx_start` with `rx_en`=1: `rx_cnt`←1, `os_cnt`←1, `first`←1. The pulse restarts timing even mid-frame.
- Mid-bit strobe:
  - `rx_cnt` target is `half` while `first`=1, else `bps_num`.
  - On reaching target: `rx_cnt`←1, `rx_mid_tick`←1, `first`←0. Otherwise increment.
- Oversample strobe: when `os_cnt`==`os_div`, `os_cnt`←1 and `rx_os_tick`←1. Otherwise increment.
- Counter comparisons use `>=` rather than `==`. A divisor shrink therefore wraps immediately and never runs past 2^CNT_W.
- Simultaneous events:
  - `tx_clr` coincident with a TX wrap: clear wins, no `tx_tick`.
  - `rx_start` coincident with an RX wrap: `rx_start` wins, no `rx_mid_tick` and no `rx_os_tick` that cycle.
  - `rst` overrides everything.

## Timing
- Reset values:
  - `tx_tick`, `rx_mid_tick`, `rx_os_tick` = 0.
  - `bps_num` = divisor selected by `baud_sel` at the reset edge.
  - Internal counters = 1; `first` = 1.
- All outputs are registered. No combinational path from inputs to outputs.
- TX latency: `tx_clr` sampled at edge k puts the first `tx_tick` high in the cycle after edge k+`bps_num`. Subsequent ticks follow every `bps_num` cycles.
- RX latency: `rx_start` sampled at edge k puts the first `rx_mid_tick` after edge k+`half`. Later mid ticks follow every `bps_num` cycles.
- `rx_os_tick` first fires after edge k+`os_div`, then every `os_div` cycles.
- A `baud_sel` change is seen on ticks starting with the period after the next `tx_tick` or `tx_clr`. The same `bps_num` drives the RX period from that point.
- Each tick is exactly one cycle wide. Two tick pulses are never adjacent unless `os_div`=1.

## Test plan
- Reset with `baud_sel`=5, then `tx_clr` at edge 0 → `bps_num`=868; `tx_tick` high for cycles following edges 868, 1736, 2604; no other highs.
- Switch `baud_sel` 5→8 mid-period → current period stays 868 cycles; `bps_num`=109 after that tick; following periods are 109 cycles.
- `baud_sel`=0, `div_custom`=1 → `bps_num`=2; `tx_tick` every 2 cycles. `div_custom`=40 → `rx_os_tick` every 2 cycles (40>>4).
- `rx_en`=1, `baud_sel`=1, `rx_start` at edge 0 → `rx_mid_tick` after edges 5208, 15625, 26042; `rx_os_tick` every 651 cycles.
- `rx_start` reissued at edge 3000 of the above → no tick at 5208; next `rx_mid_tick` after edge 8208. `rx_start` while `rx_en`=0 → no RX ticks.
- `tx_clr` on the wrap cycle, and `rst` mid-period → no `tx_tick` that cycle; outputs 0; period restarts from 1.
